// File: rtl/display_pkg.sv
// Shared types and constants for the BCD display driver: digit type, FSM
// state encoding and the largest value the 8-digit display can show.
package display_pkg;

  localparam int unsigned NUM_DIGITS  = 8;
  localparam logic [26:0] MAX_DISPLAY = 27'd99_999_999;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PUBLISH
  } dd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3
  import display_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  always_comb begin
    q = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD converter (one bit per clock) with leading-zero
// blanking; display outputs only change once a full conversion has finished.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 lz_blank_en,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           BCD7,
  output logic [3:0]           BCD6,
  output logic [3:0]           BCD5,
  output logic [3:0]           BCD4,
  output logic [3:0]           BCD3,
  output logic [3:0]           BCD2,
  output logic [3:0]           BCD1,
  output logic [3:0]           BCD0,
  output logic [7:0]           blank
);

  localparam int unsigned CW = $clog2(BIN_WIDTH + 1);
  localparam int unsigned SW = 4 * NUM_DIGITS;

  dd_state_t             state;
  dd_state_t             state_nx;

  logic [SW-1:0]         scratch;
  logic [SW-1:0]         adj;
  logic [BIN_WIDTH-1:0]  sh;
  logic [CW-1:0]         cnt;
  logic                  lz_q;
  logic                  ovf_q;
  logic                  ovf_in;

  logic                  load;
  logic                  shift_en;
  logic                  publish;
  logic                  busy_d;
  logic                  done_d;

  logic [NUM_DIGITS-1:0] nz;
  logic [7:0]            blank_d;
  logic [SW-1:0]         disp_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scratch[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; SHIFT spends one extra cycle at cnt==0 before PUBLISH
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = PUBLISH;
      PUBLISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    load     = (state == IDLE) && start;
    shift_en = (state == SHIFT) && (cnt != '0);
    publish  = (state == PUBLISH);
    busy_d   = (state_nx != IDLE);
    done_d   = publish;
  end

  always_comb begin
    ovf_in = 32'(bin_in) > 32'(MAX_DISPLAY);
  end

  // nz[i] is set when any digit from i up to the top digit is non-zero
  always_comb begin
    nz                 = '0;
    blank_d            = '0;
    nz[NUM_DIGITS-1]   = |scratch[SW-1 -: 4];
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      nz[NUM_DIGITS-1-k] = nz[NUM_DIGITS-k] | (|scratch[4*(NUM_DIGITS-1-k) +: 4]);
    end
    if (lz_q && !ovf_q) begin
      for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
        blank_d[i] = ~nz[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch  <= '0;
      sh       <= '0;
      cnt      <= '0;
      lz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      disp_q   <= '0;
      blank    <= 8'hFE;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (load) begin
        sh      <= bin_in;
        scratch <= '0;
        cnt     <= CW'(BIN_WIDTH);
        lz_q    <= lz_blank_en;
        ovf_q   <= ovf_in;
      end else if (shift_en) begin
        scratch <= (adj << 1) | SW'(sh[BIN_WIDTH-1]);
        sh      <= sh << 1;
        cnt     <= cnt - CW'(1);
      end
      if (publish) begin
        disp_q   <= ovf_q ? {NUM_DIGITS{4'd9}} : scratch;
        blank    <= blank_d;
        overflow <= ovf_q;
      end
    end
  end

  assign BCD7 = disp_q[31:28];
  assign BCD6 = disp_q[27:24];
  assign BCD5 = disp_q[23:20];
  assign BCD4 = disp_q[19:16];
  assign BCD3 = disp_q[15:12];
  assign BCD2 = disp_q[11:8];
  assign BCD1 = disp_q[7:4];
  assign BCD0 = disp_q[3:0];

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: expected results are queued when a
// conversion is launched and compared when the done pulse appears.
module tb_bcd_display_driver;

  localparam int unsigned BW = 27;

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          lz_blank_en = 1'b0;
  logic          busy, done, overflow;
  logic [3:0]    BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0;
  logic [7:0]    blank;

  exp_t        sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  logic        prev_done = 1'b0;

  bcd_display_driver #(.BIN_WIDTH(BW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .bin_in      (bin_in),
    .lz_blank_en (lz_blank_en),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .BCD7        (BCD7),
    .BCD6        (BCD6),
    .BCD5        (BCD5),
    .BCD4        (BCD4),
    .BCD3        (BCD3),
    .BCD2        (BCD2),
    .BCD1        (BCD1),
    .BCD0        (BCD0),
    .blank       (blank)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned v, input bit lz);
    exp_t        e;
    int unsigned t;
    bit          seen;
    logic [3:0]  d [8];
    e.digits = '0;
    e.blank  = '0;
    e.ovf    = 1'b0;
    e.cyc    = 0;
    if (v > 99_999_999) begin
      e.digits = 32'h9999_9999;
      e.ovf    = 1'b1;
    end else begin
      t = v;
      for (int i = 0; i < 8; i++) begin
        d[i] = 4'(t % 10);
        t    = t / 10;
        e.digits[4*i +: 4] = d[i];
      end
      seen = 1'b0;
      for (int k = 7; k >= 1; k--) begin
        seen = seen | (d[k] != 4'd0);
        e.blank[k] = lz && !seen;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] dut_digits();
    return {BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (prev_done) check("done_width", 32'(done), 32'd0);
    prev_done = done;
    if (done) begin
      check("busy_in_done", 32'(busy), 32'd0);
      if (sbq.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("digits",   dut_digits(), e.digits);
        check("blank",    32'(blank), 32'(e.blank));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("latency",  cyc, e.cyc);
      end
    end
  end

  // Launch at a falling edge; accept edge is the next rising edge.
  task automatic launch(input int unsigned v, input bit lz);
    exp_t e;
    start       = 1'b1;
    bin_in      = BW'(v);
    lz_blank_en = lz;
    e           = model(v, lz);
    e.cyc       = cyc + 1 + BW + 2;
    sbq.push_back(e);
  endtask

  task automatic do_conv(input int unsigned v, input bit lz);
    @(negedge clock);
    launch(v, lz);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clock);
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_done"},   32'(done), 32'd0);
    check({tag, "_ovf"},    32'(overflow), 32'd0);
    check({tag, "_digits"}, dut_digits(), 32'd0);
    check({tag, "_blank"},  32'(blank), 32'hFE);
  endtask

  initial begin
    bit got_done;

    @(negedge clock);
    check_reset_state("rst");
    @(negedge clock);
    reset = 1'b0;

    // Main conversions and blanking boundaries
    do_conv(12_345_678, 1'b1); wait_drain();
    do_conv(42, 1'b1);         wait_drain();
    do_conv(42, 1'b0);         wait_drain();
    do_conv(0, 1'b1);          wait_drain();
    do_conv(10_000_000, 1'b1); wait_drain();
    do_conv(99_999_999, 1'b1); wait_drain();
    do_conv(100_000_000, 1'b1); wait_drain();
    do_conv(5, 1'b1);          wait_drain();
    do_conv(134_217_727, 1'b0); wait_drain();
    do_conv(1_000, 1'b1);      wait_drain();

    // start and bin_in changes while busy are ignored; start in done cycle accepted
    do_conv(7_654_321, 1'b1);
    repeat (4) @(negedge clock);
    check("busy_mid", 32'(busy), 32'd1);
    bin_in = BW'(555);
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      @(negedge clock);
      got_done = done;
    end
    if (!got_done) check("done_timeout", 32'(got_done), 32'd1);
    launch(306, 1'b1);
    @(negedge clock);
    start = 1'b0;
    wait_drain();

    // Reset mid-conversion aborts immediately and produces no done
    do_conv(87_654_321, 1'b1);
    repeat (8) @(negedge clock);
    sbq.delete();
    #2 reset = 1'b1;
    #1 check_reset_state("midrst");
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("post_rst_busy", 32'(busy), 32'd0);

    do_conv(987_654, 1'b1); wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
